usb_tx_stuff_encoder: RTL and testbench
=======================================

USB_TX_STUFF_ENCODER -- requirements
Module: usb_tx_stuff_encoder

Interface
REQ-001 Parameter STUFF_LIMIT, default 6, consecutive transmitted 1s after which a stuff bit is inserted.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 bit_strobe  input  1  one-cycle pulse per USB bit time, from the bit-period counter rollover.
REQ-005 tx_valid  input  1  tx_data holds a byte to send.
REQ-006 tx_data  input  8  byte to send, LSB first.
REQ-007 tx_ready  output  1  holding register empty; byte accepted when tx_valid && tx_ready.
REQ-008 eop_req  input  1  one-cycle pulse requesting EOP after the last accepted byte.
REQ-009 dplus_out / dminus_out  output  1 each  encoded line levels.
REQ-010 halt  output  1  freezes the downstream bit/byte counter during a stuff bit.
REQ-011 busy  output  1  state != IDLE.
REQ-012 tx_done  output  1  one-cycle pulse when EOP completes.
REQ-013 underrun  output  1  one-cycle pulse on data starvation.
REQ-014 stuff_count  output  8  stuffed-bit counter (see Configuration).

Function
REQ-015 States SHALL be IDLE, SHIFT, STUFF, EOP_SE0_1, EOP_SE0_2, EOP_J; all transitions occur only on cycles with bit_strobe=1.
REQ-016 Holding register SHALL set full the cycle after handshake; tx_ready = !hold_full, so accept and consume never coincide.
REQ-017 eop_req SHALL latch eop_pending; cleared on entering EOP_SE0_1.
REQ-018 IDLE: on strobe, hold_full -> load shift register (clear hold_full), send bit 0, go SHIFT; else eop_pending -> EOP_SE0_1; else stay.
REQ-019 SHIFT: each strobe sends next bit; after bit 7, next strobe loads holding (stay SHIFT), else EOP if eop_pending, else pulse underrun and go EOP_SE0_1.
REQ-020 NRZI: data 0 toggles the line, data 1 holds; J = (dplus,dminus)=(1,0), K = (0,1).
REQ-021 Ones counter (3 bits) increments per transmitted 1, clears on any transmitted 0 including stuff bits.
REQ-022 When the ones counter reaches STUFF_LIMIT, the next strobe SHALL enter STUFF, send 0 (toggle), then resume with the pending data bit, byte load, or EOP.
REQ-023 Stuff after bit 7 of the final byte SHALL be sent before EOP.
REQ-024 halt = 1 combinationally exactly while state == STUFF.
REQ-025 EOP: SE0 (0,0) for EOP_SE0_1 and EOP_SE0_2, J for EOP_J, then IDLE; tx_done pulses the cycle IDLE is entered.
REQ-026 Entering IDLE SHALL reset the ones counter and NRZI level to J.
REQ-027 Line outputs SHALL be registered and change only on the strobe edge; zero added latency beyond that edge.

Reset
REQ-028 n_rst low: state IDLE, dplus_out=1, dminus_out=0, tx_ready=1, hold_full=0, eop_pending=0, ones=0, halt=0, busy=0, tx_done=0, underrun=0, stuff_count=0.
REQ-029 Reset mid-packet SHALL abort immediately to J idle with no EOP and no tx_done.

Configuration
REQ-030 Macro USB_TX_STUFF_CNT_EN defined: stuff_count increments per stuff bit, saturates at 255, clears on reset only.
REQ-031 Macro undefined: stuff_count tied to 0, no counter logic; all other behaviour identical.

Verification
REQ-032 Byte 0x00 then eop_req -> line K,J,K,J,K,J,K,J then SE0,SE0,J; tx_done once; halt never high.
REQ-033 Byte 0xFF then eop_req -> six bit times J, one STUFF bit K with halt=1 one strobe, two more K, then EOP; stuff_count=1 if enabled.
REQ-034 Bytes 0x80,0x7F back-to-back (0x7F offered while 0x80 shifts) -> gapless 16 data bits, stuff after 7th consecutive-1 run reaches 6, tx_ready low while holding full.
REQ-035 One byte, no eop_req -> after bit 7 underrun pulses once, EOP follows, tx_done pulses.
REQ-036 n_rst asserted during EOP_SE0_2 -> outputs J (1,0) asynchronously, busy=0, no tx_done; next byte transmits normally.

Source files
------------

// File: rtl/usb_tx_stuff_encoder.sv
// rtl/usb_tx_stuff_encoder.sv - USB transmit bit stuffer and NRZI line encoder with EOP generation
// Optional stuffed-bit counter enabled by defining USB_TX_STUFF_CNT_EN.
module usb_tx_stuff_encoder #(
  parameter int STUFF_LIMIT = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bit_strobe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       eop_req,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       halt,
  output logic       busy,
  output logic       tx_done,
  output logic       underrun,
  output logic [7:0] stuff_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT     = 3'd1,
    STUFF     = 3'd2,
    EOP_SE0_1 = 3'd3,
    EOP_SE0_2 = 3'd4,
    EOP_J     = 3'd5
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STUFF_LIMIT);

  state_t     state;
  state_t     next_state;
  logic [7:0] hold_data;
  logic       hold_full;
  logic       eop_pending;
  logic [7:0] shift_reg;
  logic [2:0] bit_idx;
  logic [2:0] ones;
  logic       nrzi_j;

  // per-strobe actions decided alongside the next state
  logic       load;
  logic       send_data;
  logic       data_bit;
  logic       send_stuff;
  logic       starve;
  logic       tx_bit;
  logic       line_send;

  assign tx_ready  = !hold_full;
  assign tx_bit    = send_stuff ? 1'b0 : data_bit;
  assign line_send = send_stuff || send_data;

  // state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state and per-strobe action selection; nothing moves without a strobe
  always_comb begin
    next_state = state;
    load       = 1'b0;
    send_data  = 1'b0;
    data_bit   = 1'b0;
    send_stuff = 1'b0;
    starve     = 1'b0;
    if (bit_strobe) begin
      case (state)
        IDLE: begin
          if (hold_full) begin
            load       = 1'b1;
            send_data  = 1'b1;
            data_bit   = hold_data[0];
            next_state = SHIFT;
          end else if (eop_pending) begin
            next_state = EOP_SE0_1;
          end
        end
        SHIFT, STUFF: begin
          // a stuff bit always precedes whatever comes next, including EOP
          if (state == SHIFT && ones == LIMIT) begin
            send_stuff = 1'b1;
            next_state = STUFF;
          end else if (bit_idx != 3'd7) begin
            send_data  = 1'b1;
            data_bit   = shift_reg[bit_idx + 3'd1];
            next_state = SHIFT;
          end else if (hold_full) begin
            load       = 1'b1;
            send_data  = 1'b1;
            data_bit   = hold_data[0];
            next_state = SHIFT;
          end else if (eop_pending) begin
            next_state = EOP_SE0_1;
          end else begin
            starve     = 1'b1;
            next_state = EOP_SE0_1;
          end
        end
        EOP_SE0_1: next_state = EOP_SE0_2;
        EOP_SE0_2: next_state = EOP_J;
        EOP_J:     next_state = IDLE;
        default:   next_state = IDLE;
      endcase
    end
  end

  // status outputs decoded from the current state
  always_comb begin
    halt = (state == STUFF);
    busy = (state != IDLE);
  end

  // holding register and EOP request latch; a new request wins over the clear
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_data   <= 8'd0;
      hold_full   <= 1'b0;
      eop_pending <= 1'b0;
    end else begin
      if (load) begin
        hold_full <= 1'b0;
      end else if (tx_valid && tx_ready) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end
      if (eop_req) begin
        eop_pending <= 1'b1;
      end else if (bit_strobe && next_state == EOP_SE0_1 && state != EOP_SE0_1) begin
        eop_pending <= 1'b0;
      end
    end
  end

  // shift register and index of the data bit most recently put on the line
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_reg <= 8'd0;
      bit_idx   <= 3'd0;
    end else if (load) begin
      shift_reg <= hold_data;
      bit_idx   <= 3'd0;
    end else if (send_data) begin
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // NRZI encoder, ones run counter and registered line drivers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      nrzi_j     <= 1'b1;
      ones       <= 3'd0;
      dplus_out  <= 1'b1;
      dminus_out <= 1'b0;
    end else if (line_send) begin
      if (tx_bit) begin
        ones       <= ones + 3'd1;
        dplus_out  <= nrzi_j;
        dminus_out <= !nrzi_j;
      end else begin
        ones       <= 3'd0;
        nrzi_j     <= !nrzi_j;
        dplus_out  <= !nrzi_j;
        dminus_out <= nrzi_j;
      end
    end else if (bit_strobe) begin
      case (next_state)
        EOP_SE0_1, EOP_SE0_2: begin
          dplus_out  <= 1'b0;
          dminus_out <= 1'b0;
        end
        EOP_J: begin
          dplus_out  <= 1'b1;
          dminus_out <= 1'b0;
        end
        IDLE: begin
          nrzi_j     <= 1'b1;
          ones       <= 3'd0;
          dplus_out  <= 1'b1;
          dminus_out <= 1'b0;
        end
        default: begin
          dplus_out  <= dplus_out;
          dminus_out <= dminus_out;
        end
      endcase
    end
  end

  // single-cycle completion and starvation pulses
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_done  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      tx_done  <= bit_strobe && (state == EOP_J);
      underrun <= starve;
    end
  end

`ifdef USB_TX_STUFF_CNT_EN
  logic [7:0] stuff_cnt;

  // saturating count of inserted stuff bits, cleared only by reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stuff_cnt <= 8'd0;
    end else if (send_stuff && stuff_cnt != 8'hFF) begin
      stuff_cnt <= stuff_cnt + 8'd1;
    end
  end

  assign stuff_count = stuff_cnt;
`else
  assign stuff_count = 8'd0;
`endif

endmodule

// File: tb/tb_usb_tx_stuff_encoder.sv
// tb/tb_usb_tx_stuff_encoder.sv - randomized self-checking bench for usb_tx_stuff_encoder
module tb_usb_tx_stuff_encoder;

  logic       clk;
  logic       n_rst;
  logic       bit_strobe;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       eop_req;
  logic       dplus_out;
  logic       dminus_out;
  logic       halt;
  logic       busy;
  logic       tx_done;
  logic       underrun;
  logic [7:0] stuff_count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int und_cnt = 0;
  int exp_stuff = 0;

  logic [7:0] pkt[$];
  logic [2:0] exp_sym[$];

  usb_tx_stuff_encoder #(.STUFF_LIMIT(6)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bit_strobe(bit_strobe),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .eop_req(eop_req),
    .dplus_out(dplus_out),
    .dminus_out(dminus_out),
    .halt(halt),
    .busy(busy),
    .tx_done(tx_done),
    .underrun(underrun),
    .stuff_count(stuff_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (underrun) und_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_count();
`ifdef USB_TX_STUFF_CNT_EN
    return (exp_stuff > 255) ? 255 : exp_stuff;
`else
    return 0;
`endif
  endfunction

  // Reference: stuffed bit stream, NRZI from J, then SE0 SE0 J. Entry = {dp, dm, halt}.
  task automatic build_expected();
    int run = 0;
    bit lvl = 1'b1;
    logic [7:0] b;
    exp_sym = {};
    foreach (pkt[n]) begin
      b = pkt[n];
      for (int i = 0; i < 8; i++) begin
        if (run == 6) begin
          lvl = !lvl;
          exp_sym.push_back({lvl, !lvl, 1'b1});
          run = 0;
        end
        if (b[i]) run++;
        else begin
          lvl = !lvl;
          run = 0;
        end
        exp_sym.push_back({lvl, !lvl, 1'b0});
      end
    end
    if (run == 6) begin
      lvl = !lvl;
      exp_sym.push_back({lvl, !lvl, 1'b1});
    end
    exp_sym.push_back(3'b000);
    exp_sym.push_back(3'b000);
    exp_sym.push_back(3'b100);
  endtask

  task automatic strobe_once();
    int gap = $urandom_range(2, 5);
    repeat (gap) @(negedge clk);
    bit_strobe = 1'b1;
    @(negedge clk);
    bit_strobe = 1'b0;
  endtask

  task automatic feeder(input bit with_eop);
    foreach (pkt[n]) begin
      int w = 0;
      @(negedge clk);
      while (!tx_ready && w < 500) begin
        @(negedge clk);
        w++;
      end
      if (w >= 500) begin
        check_eq("feed_timeout", 32'(w), 0);
        return;
      end
      tx_valid = 1'b1;
      tx_data  = pkt[n];
      @(negedge clk);
      tx_valid = 1'b0;
      check_eq("ready_low_when_full", tx_ready, 1'b0);
    end
    if (with_eop) begin
      eop_req = 1'b1;
      @(negedge clk);
      eop_req = 1'b0;
    end
  endtask

  task automatic wait_loaded();
    int w = 0;
    @(negedge clk);
    while (tx_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check_eq("hold_timeout", 32'(w), 0);
  endtask

  task automatic strober();
    wait_loaded();
    for (int k = 0; k < exp_sym.size(); k++) begin
      strobe_once();
      check_eq($sformatf("line_sym%0d", k), {dplus_out, dminus_out}, exp_sym[k][2:1]);
      check_eq($sformatf("halt_sym%0d", k), halt, exp_sym[k][0]);
      if (k == 0) check_eq("busy_active", busy, 1'b1);
    end
    strobe_once();
    check_eq("idle_line", {dplus_out, dminus_out}, 2'b10);
    check_eq("idle_busy", busy, 1'b0);
  endtask

  task automatic send_packet(input bit with_eop);
    int d0 = done_cnt;
    int u0 = und_cnt;
    build_expected();
    foreach (exp_sym[k]) if (exp_sym[k][0]) exp_stuff++;
    fork
      feeder(with_eop);
      strober();
    join
    @(negedge clk);
    check_eq("tx_done_pulses", 32'(done_cnt - d0), 1);
    check_eq("underrun_pulses", 32'(und_cnt - u0), with_eop ? 0 : 1);
    check_eq("stuff_count", stuff_count, 32'(exp_count()));
    check_eq("ready_after", tx_ready, 1'b1);
  endtask

  task automatic reset_in_eop();
    int d0;
    pkt = {8'h00};
    fork
      feeder(1'b1);
      begin
        wait_loaded();
        repeat (10) strobe_once();
      end
    join
    check_eq("pre_rst_se0", {dplus_out, dminus_out}, 2'b00);
    check_eq("pre_rst_busy", busy, 1'b1);
    d0 = done_cnt;
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check_eq("rst_async_line", {dplus_out, dminus_out}, 2'b10);
    check_eq("rst_async_busy", busy, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (4) strobe_once();
    exp_stuff = 0;
    check_eq("rst_no_done", 32'(done_cnt - d0), 0);
    check_eq("rst_idle_line", {dplus_out, dminus_out}, 2'b10);
    check_eq("rst_stuff_cleared", stuff_count, 0);
  endtask

  initial begin
    n_rst      = 1'b0;
    bit_strobe = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    eop_req    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_line", {dplus_out, dminus_out}, 2'b10);
    check_eq("rst_ready", tx_ready, 1'b1);
    check_eq("rst_halt", halt, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", tx_done, 1'b0);
    check_eq("rst_underrun", underrun, 1'b0);
    check_eq("rst_stuff_count", stuff_count, 0);
    n_rst = 1'b1;
    @(negedge clk);

    pkt = {8'h00};
    send_packet(1'b1);
    pkt = {8'hFF};
    send_packet(1'b1);
    pkt = {8'h80, 8'h7F};
    send_packet(1'b1);
    pkt = {8'h3C};
    send_packet(1'b0);

    reset_in_eop();
    pkt = {8'hA5};
    send_packet(1'b1);

    for (int p = 0; p < 20; p++) begin
      int len = $urandom_range(1, 4);
      pkt = {};
      for (int i = 0; i < len; i++) begin
        logic [7:0] b;
        b = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
        pkt.push_back(b);
      end
      send_packet(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
